// File: rtl/tl45_ibuf.sv
// Instruction queue between prefetch and decode. It emits a bubble (pc=0, inst=0) when it has nothing for decode.
// Optional macro TL45_IBUF_BYPASS_EN: when the queue is empty, an input goes straight to decode.
module tl45_ibuf #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_buf_pc,
  input  logic [31:0] i_buf_inst,
  output logic        o_fetch_stall,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  output logic [31:0] o_dec_pc,
  output logic [31:0] o_dec_inst
);
  localparam int PW = $clog2(DEPTH);

  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          r_fetch_adv;
  logic [31:0]   r_dec_pc;
  logic [31:0]   r_dec_inst;

  logic          w_in_valid;
  logic [PW+1:0] w_occ;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  // A fetch value that is held during a stall is not fresh, so r_fetch_adv masks it.
  assign w_in_valid = r_fetch_adv && ((i_buf_pc != '0) || (i_buf_inst != '0));

  // This ignores a pop in the same cycle, so a slot is always free for the next fetch item.
  assign w_occ         = {1'b0, r_count} + {{(PW+1){1'b0}}, w_in_valid};
  assign o_fetch_stall = (w_occ >= (PW+2)'(DEPTH));

`ifdef TL45_IBUF_BYPASS_EN
  assign w_bypass = (r_count == '0) && w_in_valid && !i_pipe_stall && !i_pipe_flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_in_valid && !i_pipe_flush && !w_bypass;
  assign w_pop  = !i_pipe_stall && !i_pipe_flush && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_buf_pc, i_buf_inst};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_fetch_adv <= 1'b0;
      r_dec_pc    <= '0;
      r_dec_inst  <= '0;
    end else if (i_pipe_flush) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_fetch_adv <= 1'b0;
      r_dec_pc    <= '0;
      r_dec_inst  <= '0;
    end else begin
      r_fetch_adv <= !o_fetch_stall;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (!i_pipe_stall) begin
        if (w_pop) begin
          {r_dec_pc, r_dec_inst} <= r_mem[r_rd_ptr];
        end else if (w_bypass) begin
          r_dec_pc   <= i_buf_pc;
          r_dec_inst <= i_buf_inst;
        end else begin
          r_dec_pc   <= '0;
          r_dec_inst <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (r_count <= (PW+1)'(DEPTH));
      assert (!(w_push && !w_pop && (r_count == (PW+1)'(DEPTH))));
    end
  end

  assign o_dec_pc   = r_dec_pc;
  assign o_dec_inst = r_dec_inst;
endmodule

// File: tb/tb_tl45_ibuf.sv
// Randomised and directed bench for tl45_ibuf, checked against a queue-based model of the instruction buffer.
module tb_tl45_ibuf;
  localparam int DEPTH = 4;
`ifdef TL45_IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_buf_pc, i_buf_inst;
  logic        o_fetch_stall;
  logic        i_pipe_stall, i_pipe_flush;
  logic [31:0] o_dec_pc, o_dec_inst;

  tl45_ibuf #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_buf_pc(i_buf_pc), .i_buf_inst(i_buf_inst),
    .o_fetch_stall(o_fetch_stall),
    .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
    .o_dec_pc(o_dec_pc), .o_dec_inst(o_dec_inst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mq[$];
  bit          m_adv;
  logic [63:0] m_dec;
  logic [31:0] next_pc;
  logic [63:0] seen[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seen(input int k, input logic [31:0] pc, input string nm);
    if (seen.size() > k) chk(nm, {32'h0, seen[k][63:32]}, {32'h0, pc});
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: only %0d items delivered, item %0d with pc %h required", nm, seen.size(), k, pc);
    end
  endtask

  // One clock: drive controls, check the stall, clock, update the model, advance fetch, check the decode outputs.
  task automatic cycle(input bit st, input bit fl, input bit bub, input logic [31:0] redir);
    bit          inv, fs, byp;
    logic [63:0] in;
    i_pipe_stall = st;
    i_pipe_flush = fl;
    #1;
    in  = {i_buf_pc, i_buf_inst};
    inv = m_adv && (in != 64'h0);
    fs  = (mq.size() + (inv ? 1 : 0)) >= DEPTH;
    chk("fetch_stall", {63'h0, o_fetch_stall}, {63'h0, fs});
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      m_dec = 64'h0;
      m_adv = 1'b0;
    end else begin
      byp = BYP && (mq.size() == 0) && inv && !st;
      if (!st) begin
        if (mq.size() > 0) m_dec = mq.pop_front();
        else if (byp)      m_dec = in;
        else               m_dec = 64'h0;
      end
      if (inv && !byp) mq.push_back(in);
      m_adv = !fs;
    end
    if (fl) begin
      i_buf_pc = 32'h0; i_buf_inst = 32'h0; next_pc = redir;
    end else if (!fs) begin
      if (bub) begin
        i_buf_pc = 32'h0; i_buf_inst = 32'h0;
      end else begin
        i_buf_pc = next_pc; i_buf_inst = {next_pc[15:0], 16'hC0DE}; next_pc += 32'd4;
      end
    end
    @(negedge clk);
    chk("dec_pc",   {32'h0, o_dec_pc},   {32'h0, m_dec[63:32]});
    chk("dec_inst", {32'h0, o_dec_inst}, {32'h0, m_dec[31:0]});
    if (!st && !fl && (o_dec_pc != 32'h0 || o_dec_inst != 32'h0)) seen.push_back({o_dec_pc, o_dec_inst});
  endtask

  task automatic async_reset();
    #2 i_reset_n = 1'b0;
    #1;
    chk("rst_pc",     {32'h0, o_dec_pc},   64'h0);
    chk("rst_inst",   {32'h0, o_dec_inst}, 64'h0);
    chk("rst_fstall", {63'h0, o_fetch_stall}, 64'h0);
    mq.delete(); m_adv = 1'b0; m_dec = 64'h0;
    i_buf_pc = 32'h0; i_buf_inst = 32'h0; next_pc = 32'h0;
    i_pipe_stall = 1'b0; i_pipe_flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    int lat;
    i_reset_n = 1'b0; i_buf_pc = 32'h0; i_buf_inst = 32'h0;
    i_pipe_stall = 1'b0; i_pipe_flush = 1'b0;
    m_adv = 1'b0; m_dec = 64'h0; next_pc = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pc",     {32'h0, o_dec_pc}, 64'h0);
    chk("reset_fstall", {63'h0, o_fetch_stall}, 64'h0);
    i_reset_n = 1'b1;

    // Stream from reset: the first item is accepted at edge 2 and appears at edge 3 (edge 2 with bypass).
    lat = BYP ? 2 : 3;
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      if (i >= lat && i < lat + 3) chk("stream_pc", {32'h0, o_dec_pc}, {32'h0, 32'h100 + 32'(4 * (i - lat))});
    end

    // Asynchronous reset mid-stream, then fetch restarts at pc 0.
    async_reset();
    seen.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk_seen(0, 32'h0, "reset_resume_pc");
    if (seen.size() > 0) chk("reset_resume_inst", {32'h0, seen[0][31:0]}, 64'h0000_C0DE);

    // Decode stalled for 6 cycles under continuous fetch.
    cycle(1'b0, 1'b1, 1'b0, 32'h100);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("peak_count", 64'(mq.size()), 64'd4);
    chk("full_fstall", {63'h0, o_fetch_stall}, 64'h1);
    seen.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) chk_seen(k, 32'h100 + 32'(4 * k), "drain_order");

    // Flush while three items are queued.
    cycle(1'b0, 1'b1, 1'b0, 32'h300);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("preflush_count", 64'(mq.size()), 64'd3);
    cycle(1'b1, 1'b1, 1'b0, 32'h400);
    chk("flush_pc", {32'h0, o_dec_pc}, 64'h0);
    chk("flush_count", 64'(mq.size()), 64'd0);
    seen.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk_seen(0, 32'h400, "post_flush_first");

    // Fetch bubble between 0x200 and 0x204.
    cycle(1'b0, 1'b1, 1'b0, 32'h200);
    seen.delete();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk_seen(0, 32'h200, "bubble_first");
    chk_seen(1, 32'h204, "bubble_second");

    // Steady push+pop at count 2, wrapping the pointers several times.
    cycle(1'b0, 1'b1, 1'b0, 32'h500);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    seen.delete();
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("steady_count", 64'(mq.size()), 64'd2);
    for (int k = 0; k < 10; k++) chk_seen(k, 32'h500 + 32'(4 * k), "wrap_order");

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 2) async_reset();
      else cycle(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 99) < 15), 32'($urandom_range(1, 4095)) << 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
